image_stream_read: RTL and testbench
====================================

IMAGE_STREAM_READ -- requirements
Module: image_stream_read

Interface
REQ-001 The block SHALL have parameter WIDTH, default 768, image width in pixels (even).
REQ-002 The block SHALL have parameter HEIGHT, default 512, image height in rows.
REQ-003 The block SHALL have parameter START_UP_DELAY, default 100, VSYNC-phase length in cycles (>=1).
REQ-004 The block SHALL have parameter HSYNC_DELAY, default 160, inter-row gap in cycles (>=1).
REQ-005 The block SHALL have parameter ADDR_W, default 18, memory word-address width (>= clog2(WIDTH*HEIGHT/2)).
REQ-006 The block SHALL have port HCLK, input, 1 bit, the single clock.
REQ-007 The block SHALL have port HRESETn, input, 1 bit, reset, asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit, one-cycle frame-start request.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W bits, pixel-pair word address.
REQ-010 The block SHALL have port mem_rd, output, 1 bit, read strobe.
REQ-011 The block SHALL have port mem_rdata, input, 48 bits, word returned exactly 1 cycle after mem_rd.
REQ-012 The block SHALL have port VSYNC, output, 1 bit, high during start-up phase.
REQ-013 The block SHALL have port HSYNC, output, 1 bit, pixel-pair valid.
REQ-014 The block SHALL have ports DATA_R0/G0/B0/R1/G1/B1, outputs, 8 bits each, two RGB pixels per beat (0 = left pixel).
REQ-015 The block SHALL have port ctrl_done, output, 1 bit, one-cycle end-of-frame pulse.

Function
REQ-016 The FSM SHALL have states ST_IDLE, ST_VSYNC, ST_HSYNC, ST_DATA.
REQ-017 In ST_IDLE, start=1 SHALL move to ST_VSYNC; start in any other state SHALL be ignored.
REQ-018 ST_VSYNC SHALL last exactly START_UP_DELAY cycles with VSYNC=1, then go to ST_HSYNC.
REQ-019 ST_HSYNC SHALL last exactly HSYNC_DELAY cycles with no reads, then go to ST_DATA.
REQ-020 ST_DATA SHALL assert mem_rd for exactly WIDTH/2 consecutive cycles (one row), column m = 0..WIDTH/2-1.
REQ-021 At the end of a row, the FSM SHALL go to ST_HSYNC if rows remain, else to ST_IDLE.
REQ-022 Output row l (0 = top) SHALL read mem_addr = (HEIGHT-1-l)*(WIDTH/2) + m, i.e. bottom-up BMP storage order.
REQ-023 HSYNC and DATA_* SHALL be registered and valid exactly 1 cycle after the corresponding mem_rd cycle.
REQ-024 Byte lanes SHALL be B0=mem_rdata[7:0], G0=[15:8], R0=[23:16], B1=[31:24], G1=[39:32], R1=[47:40].
REQ-025 When HSYNC=0, DATA_* SHALL hold 0.
REQ-026 ctrl_done SHALL pulse for 1 cycle in the cycle after the final HSYNC beat of the frame (beat WIDTH*HEIGHT/2).
REQ-027 After ctrl_done, a new start SHALL be accepted from the same cycle ctrl_done is high onward, because the FSM is already in ST_IDLE.
REQ-028 The row counter SHALL wrap to 0 and the column counter SHALL wrap to 0 on frame end; mem_addr SHALL never exceed WIDTH*HEIGHT/2-1.

Reset
REQ-029 HRESETn=0 SHALL immediately force ST_IDLE, and clear all counters, mem_rd, mem_addr, VSYNC, HSYNC, DATA_*, and ctrl_done to 0.
REQ-030 Reset mid-frame SHALL discard any in-flight read, so that no HSYNC follows the deassertion of reset until a new start.

Structure
REQ-031 Package img_pkg SHALL hold the state enumeration, the byte-lane offsets, and the BMP header length constant (54).
REQ-032 Row/column counting SHALL be a sub-module img_frame_counter (enable, wrap at WIDTH/2 columns and HEIGHT rows, last-beat flag).
REQ-033 No frame buffer SHALL be inside the block; pixel storage SHALL be external behind the mem_* port.

Verification (WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2, mem word k = {k,k,k,k,k,k} bytes)
REQ-034 Test: start pulse -> VSYNC high for 3 cycles, 2 idle cycles, then 4 HSYNC beats with DATA_R0=12,13,14,15 (bottom row first in memory = top row out).
REQ-035 Test: full frame -> exactly 16 HSYNC beats in 4 groups of 4, each group separated by 2 cycles, then ctrl_done high for 1 cycle and 0 thereafter.
REQ-036 Test: lane check with mem_rdata=48'h060504030201 -> B0=01, G0=02, R0=03, B1=04, G1=05, R1=06.
REQ-037 Test: start re-pulsed during ST_DATA -> ignored; beat count stays 16 and VSYNC does not re-assert.
REQ-038 Test: HRESETn low during row 2 -> all outputs 0 asynchronously; after release, no HSYNC until start, then a complete 16-beat frame.
REQ-039 Test: back-to-back start in the ctrl_done cycle -> second frame identical to first.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the BMP-order image streamer: FSM states, pixel-pair byte lanes, BMP header length.
// Pure declarations; no logic, no latency, no flow control.
package img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VSYNC = 2'd1,
    ST_HSYNC = 2'd2,
    ST_DATA  = 2'd3
  } state_e;

  localparam int PIX_W       = 8;
  localparam int WORD_W      = 48;

  // A memory word packs two BGR pixels, left pixel in the low half.
  localparam int LANE_B0     = 0;
  localparam int LANE_G0     = 8;
  localparam int LANE_R0     = 16;
  localparam int LANE_B1     = 24;
  localparam int LANE_G1     = 32;
  localparam int LANE_R1     = 40;

  localparam int BMP_HDR_LEN = 54;

endpackage

// File: rtl/img_frame_counter.sv
// Column/row position of the current pixel-pair read; advances by one beat per enabled cycle, 0-cycle flags.
// No backpressure: counts whenever en is high and wraps to 0,0 after the last beat of a frame.
module img_frame_counter #(
  parameter int COLS = 384,
  parameter int ROWS = 512,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          row_end,
  output logic          last_beat
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (en) begin
      if (row_end) begin
        col_d = '0;
        row_d = last_beat ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  assign row_end   = (col_q == CW'(COLS - 1));
  assign last_beat = row_end && (row_q == RW'(ROWS - 1));
  assign col       = col_q;
  assign row       = row_q;

endmodule

// File: rtl/image_stream_read.sv
// Streams a bottom-up BMP frame from external memory as VSYNC/HSYNC + two RGB pixels per beat; 1 cycle mem_rd->HSYNC.
// No backpressure: timing is free-running once started; start is only honoured in ST_IDLE.
module image_stream_read
  import img_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = 18
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [47:0]       mem_rdata,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [7:0]        DATA_R0,
  output logic [7:0]        DATA_G0,
  output logic [7:0]        DATA_B0,
  output logic [7:0]        DATA_R1,
  output logic [7:0]        DATA_G1,
  output logic [7:0]        DATA_B1,
  output logic              ctrl_done
);

  localparam int COLS    = WIDTH / 2;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DW      = $clog2(DLY_MAX + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          hsync_q, hsync_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             row_end;
  logic             last_beat;
  logic [ADDR_W-1:0] addr_c;

  img_frame_counter #(
    .COLS (COLS),
    .ROWS (HEIGHT),
    .CW   (COL_W),
    .RW   (ROW_W)
  ) u_cnt (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .en        (mem_rd),
    .col       (col),
    .row       (row),
    .row_end   (row_end),
    .last_beat (last_beat)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      hsync_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      hsync_q <= hsync_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_VSYNC;
          dly_d   = '0;
        end
      end
      ST_VSYNC: begin
        if (dly_q == DW'(START_UP_DELAY - 1)) begin
          state_d = ST_HSYNC;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      ST_HSYNC: begin
        if (dly_q == DW'(HSYNC_DELAY - 1)) begin
          state_d = ST_DATA;
          dly_d   = '0;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      ST_DATA: begin
        if (row_end) begin
          state_d = last_beat ? ST_IDLE : ST_HSYNC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dly_d   = '0;
      end
    endcase
  end

  // Output row 0 is the last row stored in memory (BMP is bottom-up).
  always_comb begin
    addr_c = (ADDR_W'(HEIGHT - 1) - ADDR_W'(row)) * ADDR_W'(COLS) + ADDR_W'(col);
  end

  assign mem_rd   = (state_q == ST_DATA);
  assign mem_addr = mem_rd ? addr_c : '0;
  assign VSYNC    = (state_q == ST_VSYNC);

  always_comb begin
    hsync_d = mem_rd;
    last_d  = mem_rd && last_beat;
    done_d  = last_q;
  end

  // Read data lands in the cycle after mem_rd, aligned with hsync_q.
  assign HSYNC     = hsync_q;
  assign DATA_B0   = hsync_q ? mem_rdata[LANE_B0 +: PIX_W] : 8'd0;
  assign DATA_G0   = hsync_q ? mem_rdata[LANE_G0 +: PIX_W] : 8'd0;
  assign DATA_R0   = hsync_q ? mem_rdata[LANE_R0 +: PIX_W] : 8'd0;
  assign DATA_B1   = hsync_q ? mem_rdata[LANE_B1 +: PIX_W] : 8'd0;
  assign DATA_G1   = hsync_q ? mem_rdata[LANE_G1 +: PIX_W] : 8'd0;
  assign DATA_R1   = hsync_q ? mem_rdata[LANE_R1 +: PIX_W] : 8'd0;
  assign ctrl_done = done_q;

endmodule

// File: tb/tb_image_stream_read.sv
// Directed bench for image_stream_read on an 8x4 frame with a 1-cycle synchronous memory model.
module tb_image_stream_read;

  localparam logic [47:0] LANE_WORD = 48'h060504030201;

  logic        HCLK;
  logic        HRESETn;
  logic        start;
  logic [3:0]  mem_addr;
  logic        mem_rd;
  logic [47:0] mem_rdata;
  logic        VSYNC;
  logic        HSYNC;
  logic [7:0]  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
  logic        ctrl_done;
  logic        lane_mode;

  int n_tests;
  int n_fail;

  image_stream_read #(
    .WIDTH          (8),
    .HEIGHT         (4),
    .START_UP_DELAY (3),
    .HSYNC_DELAY    (2),
    .ADDR_W         (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .DATA_R0   (DATA_R0),
    .DATA_G0   (DATA_G0),
    .DATA_B0   (DATA_B0),
    .DATA_R1   (DATA_R1),
    .DATA_G1   (DATA_G1),
    .DATA_B1   (DATA_B1),
    .ctrl_done (ctrl_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Word k holds byte k in every lane.
  always @(posedge HCLK) begin
    if (mem_rd) mem_rdata <= lane_mode ? LANE_WORD : {6{{4'd0, mem_addr}}};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " vsync"}, VSYNC, 0);
    chk({tag, " hsync"}, HSYNC, 0);
    chk({tag, " mem_rd"}, mem_rd, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " done"}, ctrl_done, 0);
    chk({tag, " data"}, {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}, 0);
  endtask

  // Caller raises start before the next posedge; cycle c is the interval after the c-th edge.
  // Expected: VSYNC c0-2, reads c5-8/11-14/17-20/23-26, HSYNC one cycle later, done at c28.
  task automatic run_frame(input string tag, input int restart_cyc, input bit chain);
    int  beats;
    bit  rd_e, hs_e;
    int  ph;
    beats = 0;
    for (int c = 0; c <= 28; c++) begin
      @(posedge HCLK); #1;
      start = (c == restart_cyc) || (chain && c == 28);
      rd_e = (c >= 5) && (((c - 5) % 6) < 4) && (((c - 5) / 6) < 4);
      hs_e = (c >= 6) && (((c - 6) % 6) < 4) && (((c - 6) / 6) < 4);
      chk($sformatf("%s c%0d vsync", tag, c), VSYNC, c < 3);
      chk($sformatf("%s c%0d mem_rd", tag, c), mem_rd, rd_e);
      chk($sformatf("%s c%0d hsync", tag, c), HSYNC, hs_e);
      chk($sformatf("%s c%0d done", tag, c), ctrl_done, c == 28);
      if (rd_e) begin
        ph = c - 5;
        chk($sformatf("%s c%0d addr", tag, c), mem_addr, (3 - ph / 6) * 4 + ph % 6);
      end
      if (hs_e) begin
        ph = c - 6;
        chk($sformatf("%s c%0d r0", tag, c), DATA_R0, (3 - ph / 6) * 4 + ph % 6);
      end else begin
        chk($sformatf("%s c%0d r0 idle", tag, c), DATA_R0, 0);
      end
      beats += int'(HSYNC);
    end
    if (!chain) begin
      for (int c = 29; c < 34; c++) begin
        @(posedge HCLK); #1;
        chk($sformatf("%s c%0d post", tag, c), {VSYNC, HSYNC, ctrl_done}, 0);
        beats += int'(HSYNC);
      end
    end
    chk({tag, " beats"}, beats, 16);
  endtask

  initial begin
    bit found;
    int quiet_hs;
    n_tests   = 0;
    n_fail    = 0;
    HRESETn   = 1'b0;
    start     = 1'b0;
    lane_mode = 1'b0;
    mem_rdata = '0;

    repeat (3) @(posedge HCLK);
    #1;
    chk_all_zero("reset");
    #3 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk_all_zero("post_reset");

    start = 1'b1;
    run_frame("frame1", -1, 1'b0);

    start = 1'b1;
    run_frame("restart", 7, 1'b0);

    // Byte-lane mapping on a fixed memory word.
    lane_mode = 1'b1;
    start     = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge HCLK); #1;
      start = 1'b0;
      if (HSYNC) begin
        found = 1'b1;
        break;
      end
    end
    chk("lane hsync seen", found, 1);
    chk("lane b0", DATA_B0, 8'h01);
    chk("lane g0", DATA_G0, 8'h02);
    chk("lane r0", DATA_R0, 8'h03);
    chk("lane b1", DATA_B1, 8'h04);
    chk("lane g1", DATA_G1, 8'h05);
    chk("lane r1", DATA_R1, 8'h06);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge HCLK); #1;
      if (ctrl_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("lane done seen", found, 1);
    lane_mode = 1'b0;
    @(posedge HCLK); #1;

    // Asynchronous reset during row 2 output.
    start = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      @(posedge HCLK); #1;
      start = 1'b0;
    end
    chk("rst pre hsync", HSYNC, 1);
    chk("rst pre r0", DATA_R0, 5);
    #2 HRESETn = 1'b0;
    #1;
    chk_all_zero("rst async");
    @(posedge HCLK); #1;
    chk_all_zero("rst held");
    @(negedge HCLK);
    HRESETn  = 1'b1;
    quiet_hs = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge HCLK); #1;
      quiet_hs += int'(HSYNC) + int'(VSYNC) + int'(mem_rd);
    end
    chk("rst quiet", quiet_hs, 0);
    start = 1'b1;
    run_frame("after_rst", -1, 1'b0);

    // Second start lands in the ctrl_done cycle.
    start = 1'b1;
    run_frame("b2b_first", -1, 1'b1);
    run_frame("b2b_second", -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
